wptr_full_lvl: RTL and testbench

WPTR_FULL_LVL -- requirements
Module: wptr_full_lvl

---
 rtl/wptr_full_lvl.sv | 99 +++++++++
 tb/tb_wptr_full_lvl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_lvl.sv
// Write-side FIFO pointer: Gray write pointer, full/almost-full flags, occupancy level and
// sticky overflow. Define WPTR_FULL_RSYNC_EN to synchronise wrptr internally with two flops.
module wptr_full_lvl #(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wrptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbnext;
  logic [ADDRSIZE:0] wgnext;
  logic [ADDRSIZE:0] rsync;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] lvl_next;
  logic [ADDRSIZE:0] full_pattern;
  logic              winc_ok;
  logic              wfull_next;
  logic              afull_next;

`ifdef WPTR_FULL_RSYNC_EN
  logic [ADDRSIZE:0] rsync_q1;
  logic [ADDRSIZE:0] rsync_q2;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rsync_q1 <= '0;
      rsync_q2 <= '0;
    end else begin
      rsync_q1 <= wrptr;
      rsync_q2 <= rsync_q1;
    end
  end

  assign rsync = rsync_q2;
`else
  // Caller already delivers a pointer that is safe in the wclk domain.
  assign rsync = wrptr;
`endif

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(rsync >> i);
    end
  end

  always_comb begin
    winc_ok      = winc & ~wfull;
    wbnext       = wbin + {{ADDRSIZE{1'b0}}, winc_ok};
    wgnext       = wbnext ^ (wbnext >> 1);
    lvl_next     = wbnext - rbin;
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    full_pattern = {~rsync[ADDRSIZE:ADDRSIZE-1], rsync[ADDRSIZE-2:0]};
    wfull_next   = (wgnext == full_pattern);
    afull_next   = (lvl_next >= afull_thresh);
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbnext;
      wptr         <= wgnext;
      wfull        <= wfull_next;
      walmost_full <= afull_next;
      wlevel       <= lvl_next;
    end
  end

  // Set has priority over clear so a concurrent overflow is never lost.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (wclr_ovf) begin
      woverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Self-checking bench for wptr_full_lvl: directed scenarios then random traffic against a
// word-count reference model.
module tb_wptr_full_lvl;

  localparam int unsigned ADDRSIZE = 4;
  localparam int Depth = 16;

  logic                wclk = 1'b0;
  logic                wrst;
  logic                winc;
  logic [ADDRSIZE:0]   wrptr;
  logic [ADDRSIZE:0]   afull_thresh;
  logic                wclr_ovf;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  wptr_full_lvl #(.ADDRSIZE(ADDRSIZE)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wrptr        (wrptr),
    .afull_thresh (afull_thresh),
    .wclr_ovf     (wclr_ovf),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counts of words written/read since reset.
  int wr_count;
  int rd_count;
  int p1;
  int p2;
  int m_level;
  bit m_full;
  bit m_afull;
  bit m_ovf;

  function automatic logic [ADDRSIZE:0] gray(input int v);
    int b;
    b = v % 32;
    return 5'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 32'(wr_count % Depth));
    chk({tag, ".wptr"}, 32'(wptr), 32'(gray(wr_count)));
    chk({tag, ".wfull"}, 32'(wfull), 32'(m_full));
    chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(m_afull));
    chk({tag, ".wlevel"}, 32'(wlevel), 32'(m_level));
    chk({tag, ".woverflow"}, 32'(woverflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    wr_count = 0;
    rd_count = 0;
    p1 = 0;
    p2 = 0;
    m_level = 0;
    m_full = 0;
    m_afull = 0;
    m_ovf = 0;
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input string tag, input bit w, input bit clr);
    int rd_used;
    bit acc;
    winc = w;
    wclr_ovf = clr;
    wrptr = gray(rd_count);
    @(posedge wclk);
`ifdef WPTR_FULL_RSYNC_EN
    rd_used = p2;
    p2 = p1;
    p1 = rd_count;
`else
    rd_used = rd_count;
`endif
    acc = w && !m_full;
    if (w && m_full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (acc) wr_count++;
    m_level = wr_count - rd_used;
    m_full = (m_level == Depth);
    m_afull = (m_level >= int'(afull_thresh));
    #1;
    check_all(tag);
  endtask

  initial begin
    wrst = 1'b1;
    winc = 1'b0;
    wclr_ovf = 1'b0;
    wrptr = '0;
    afull_thresh = 5'd16;
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    check_all("reset");
    @(negedge wclk);
    wrst = 1'b0;

    // Fill 16 words from empty.
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0);
    chk("fill.wptr_11000", 32'(wptr), 32'h18);
    chk("fill.wfull", 32'(wfull), 32'd1);

    // Write attempts while full.
    for (int i = 0; i < 3; i++) step("ovf", 1'b1, 1'b0);
    chk("ovf.sticky", 32'(woverflow), 32'd1);
    step("clr_alone", 1'b0, 1'b1);
    chk("clr_alone.ovf", 32'(woverflow), 32'd0);
    step("ovf_again", 1'b1, 1'b0);
    step("clr_and_winc", 1'b1, 1'b1);
    chk("clr_and_winc.ovf", 32'(woverflow), 32'd1);
    step("clr_final", 1'b0, 1'b1);

    // Read pointer 0 -> 1 while full: full drops after the sync latency.
    rd_count = 1;
    for (int i = 0; i < 4; i++) step("unfull", 1'b0, 1'b0);
    chk("unfull.wfull", 32'(wfull), 32'd0);

    // Almost-full threshold at 12 words.
    @(negedge wclk);
    wrst = 1'b1;
    model_reset();
    #1;
    check_all("rst2");
    wrst = 1'b0;
    afull_thresh = 5'd12;
    for (int i = 0; i < 11; i++) step("afill", 1'b1, 1'b0);
    chk("afill.below", 32'(walmost_full), 32'd0);
    step("afill12", 1'b1, 1'b0);
    chk("afill12.afull", 32'(walmost_full), 32'd1);
    rd_count = 1;
    for (int i = 0; i < 3; i++) step("adrain", 1'b0, 1'b0);
    chk("adrain.level", 32'(wlevel), 32'd11);
    chk("adrain.afull", 32'(walmost_full), 32'd0);

    // Threshold 0 and above depth.
    afull_thresh = 5'd0;
    step("thr0", 1'b0, 1'b0);
    afull_thresh = 5'd17;
    step("thr17", 1'b1, 1'b0);

    // 40 writes with reader trailing closely: pointer wraps, never full.
    afull_thresh = 5'd8;
    for (int i = 0; i < 40; i++) begin
      if (wr_count > 1) rd_count = wr_count - 1;
      step("wrap", 1'b1, 1'b0);
    end

    // Level 7 then reset pulsed between edges.
    rd_count = wr_count;
    repeat (3) step("settle", 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("lvl7", 1'b1, 1'b0);
    repeat (3) step("lvl7h", 1'b0, 1'b0);
    chk("lvl7.level", 32'(wlevel), 32'd7);
    wrst = 1'b1;
    model_reset();
    #1;
    check_all("midrst");
    #1;
    wrst = 1'b0;
    step("postrst", 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) afull_thresh = 5'($urandom_range(0, 18));
      if ($urandom_range(0, 2) != 0 && rd_count < wr_count) rd_count++;
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
